// File: rtl/aes_key_schedule_seq_pkg.sv
// Shared constants and types for the iterative AES-128 key schedule.
package aes_key_schedule_seq_pkg;

    localparam int WORD_W = 32;
    localparam int KEY_W  = 128;

    // Round constants for rounds 1..10 (index 0 is the round-1 constant).
    localparam logic [7:0] AES_RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

endpackage

// File: rtl/aes_key_schedule_seq_sbox_byte.sv
// Combinational forward AES S-box for one byte.
module aes_sbox_byte (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Table lookup; pure combinational.
    always_comb begin
        sub_val = SBOX[byte_val];
    end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128 key expansion: one round key per clock into a
// round-key store, exposed as a flat bus and a random-access read port.
module aes_key_schedule_seq
    import aes_key_schedule_seq_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [KEY_W-1:0]          key_in,
    input  logic [3:0]                rk_idx,
    output logic [KEY_W-1:0]          rk_out,
    output logic [(Nr+1)*KEY_W-1:0]   all_keys,
    output logic                      busy,
    output logic                      done
);

    // Only AES-128 is implemented; anything else must fail elaboration.
    if (Nk != 4 || Nr != 10) begin : g_bad_params
        $error("aes_key_schedule_seq supports only Nk=4, Nr=10");
    end

    ks_state_t          state;
    logic [3:0]         round;
    logic [7:0]         rcon;
    logic [KEY_W-1:0]   store [Nr+1];

    logic [3:0]         prev_idx;
    logic [KEY_W-1:0]   prev_key;
    logic [WORD_W-1:0]  w0, w1, w2, w3;
    logic [WORD_W-1:0]  rot_word, sub_word, temp;
    logic [WORD_W-1:0]  n0, n1, n2, n3;
    logic [KEY_W-1:0]   next_key;

    // Previous round key and its four words; round is >=1 whenever it matters.
    always_comb begin
        prev_idx = (round == 4'd0) ? 4'd0 : round - 4'd1;
        prev_key = store[prev_idx];
        w0       = prev_key[127:96];
        w1       = prev_key[95:64];
        w2       = prev_key[63:32];
        w3       = prev_key[31:0];
        rot_word = {w3[23:0], w3[31:24]};
    end

    // SubWord: one S-box per byte of the rotated last word.
    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox_byte u_sbox (
            .byte_val (rot_word[b*8 +: 8]),
            .sub_val  (sub_word[b*8 +: 8])
        );
    end

    // Next round key: chained XOR of the previous words with the mixed temp word.
    always_comb begin
        temp     = sub_word ^ {rcon, 24'h0};
        n0       = w0 ^ temp;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Control FSM and round-key store; start is only honoured when not busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            round <= 4'd0;
            rcon  <= 8'h01;
            for (int k = 0; k <= Nr; k++) begin
                store[k] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        store[0] <= key_in;
                        round    <= 4'd1;
                        rcon     <= 8'h01;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= EXPAND;
                    end
                end
                EXPAND: begin
                    store[round] <= next_key;
                    if (round == 4'(Nr)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        round <= round + 4'd1;
                        rcon  <= AES_RCON[round];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Random-access read port; indices beyond the last round read as zero.
    always_comb begin
        rk_out = '0;
        if (rk_idx <= 4'(Nr)) begin
            rk_out = store[rk_idx];
        end
    end

    // Flat key bus: round 0 in the most significant slice.
    always_comb begin
        all_keys = '0;
        for (int k = 0; k <= Nr; k++) begin
            all_keys[(Nr-k)*KEY_W +: KEY_W] = store[k];
        end
    end

endmodule

// File: doc/aes_key_schedule_seq.md
Name: aes_key_schedule_seq

Overview:
Iterative, clocked AES-128 key expansion stage that sits directly upstream of AESEncrypt/AESDecrypt. It replaces the combinational KeyExpansion in timing-critical builds. On a start pulse it latches a 128-bit cipher key and generates one round key per clock into an internal round-key store. It then presents the full (Nr+1)*128-bit key bus plus a random-access round-key read port, and raises a done flag.

Parameters:
Nk, 4, key length in 32-bit words; only 4 is supported, other values are a synthesis-time error.
Nr, 10, number of rounds; only 10 is supported; sets store depth Nr+1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to expand key_in
key_in  input  128  cipher key; byte 0 in bits [127:120]
rk_idx  input  4  round-key index for the read port (0..Nr)
rk_out  output  128  round key rk_idx, combinational read of the store
all_keys  output  (Nr+1)*128  all round keys; round 0 in bits [(Nr+1)*128-1 -: 128], round Nr in [127:0]
busy  output  1  expansion in progress
done  output  1  store holds a complete, valid schedule

Behaviour:
- Reset (async, active-high): FSM to IDLE; busy=0, done=0; store cleared to 0, so all_keys=0 and rk_out=0; round counter=0; Rcon register=8'h01.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE or DONE, with start=1 at the edge: store[0]<=key_in, round<=1, rcon<=01, done<=0, busy<=1, next state EXPAND.
  - EXPAND, each cycle:
    - Compute store[round] from store[round-1] using FIPS-197.
    - temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
    - w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
    - Advance rcon by xtime: 01,02,04,08,10,20,40,80,1b,36.
    - round<=round+1.
  - EXPAND with round==Nr: write the last key, then busy<=0, done<=1, next state DONE.
- Latency: start sampled at edge 0; done=1 is visible after edge Nr (10 cycles). store[k] is valid after edge k.
- start while busy=1 is ignored; the expansion in flight completes undisturbed.
- start while in DONE restarts expansion. done drops the cycle after start is sampled; earlier store entries keep stale values until overwritten.
- Consumers must only use all_keys/rk_out while done=1.
- rk_idx > Nr: rk_out=0.
- Reset asserted mid-EXPAND: immediate return to IDLE with a cleared store; no partial done.
- The done=1 and start=1 edge case follows the restart rule above.
- Only one SubWord is needed per cycle: 4 S-box lookups, combinational.

Decomposition:
- Shared package/include holds:
  - the AES_RCON constant table
  - the state encodings IDLE/EXPAND/DONE
  - the constant localparams WORD_W=32 and KEY_W=128
- One sub-module is natural: aes_sbox_byte (8-bit combinational forward S-box). It is instantiated 4 times for SubWord and is shared with the encrypt path.

Test Plan:
1. Key 000102030405060708090a0b0c0d0e0f, start pulse -> done after exactly 10 cycles. rk_idx=0 gives the key itself. rk_idx=1 gives d6aa74fdd2af72fadaa678f1d6ab76fe. rk_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5. all_keys[127:0] equals the round-10 value.
2. Key 2b7e151628aed2a6abf7158809cf4f3c -> rk_idx=1 gives a0fafe1788542cb123a339392a6c7605. rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
3. Second start pulse during cycle 4 of an expansion -> ignored; done still at cycle 10 with the first key's schedule; busy stays high continuously.
4. Reset asserted during cycle 6 of EXPAND -> busy=0, done=0, all_keys=0 immediately (asynchronous). A new start afterwards completes normally in 10 cycles.
5. After done with key A, start with key B -> done low for exactly 10 cycles, then store equals B's schedule. rk_idx=15 gives rk_out=0.
6. Feed all_keys into AESEncrypt with data 00112233445566778899aabbccddeeff and key 000102…0f -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
